// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - shared size encodings, FSM states and byte-enable helper for the data memory responder
package data_mem_resp_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // lane is expected to be already aligned for half/word accesses
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// rtl/data_mem_resp_dmem_array.sv - DEPTH_WORDS x 32 storage, synchronous read, per-byte write enables
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - pipeline data memory responder (IDLE/ACCESS/RESP); DMEM_MISALIGN_TRAP_EN makes misaligned accesses errors
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept;
    logic        size_err, range_err, misalign_err, acc_err;
    logic [1:0]  lane;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata, mem_rdata, lane_data, load_data;

    assign accept      = req_valid_i && (state_q == ST_IDLE);
    assign req_ready_o = (state_q == ST_IDLE);

    assign size_err  = (size_q == 2'd3);
    assign range_err = |addr_q[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_err = ((size_q == SIZE_HALF) && addr_q[0]) ||
                          ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
    assign lane         = addr_q[1:0];
`else
    assign misalign_err = 1'b0;
    always_comb begin
        lane = addr_q[1:0];
        if (size_q == SIZE_HALF) lane = {addr_q[1], 1'b0};
        else if (size_q == SIZE_WORD) lane = 2'b00;
    end
`endif

    assign acc_err   = size_err || range_err || misalign_err;
    assign mem_wdata = wdata_q << {lane, 3'b000};
    // Reset in the ACCESS cycle must also kill the write, not just the response
    assign mem_we    = (state_q == ST_ACCESS && we_q && !acc_err && !rst) ?
                       byte_en(size_q, lane) : 4'b0000;

    // Read is launched at acceptance so the word is available during ACCESS
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .re_i    (accept),
        .raddr_i (req_addr_i[AW+1:2]),
        .rdata_o (mem_rdata),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (mem_wdata)
    );

    assign lane_data = mem_rdata >> {lane, 3'b000};

    always_comb begin
        load_data = lane_data;
        case (size_q)
            SIZE_BYTE: load_data = uns_q ? {24'h0, lane_data[7:0]} :
                                           {{24{lane_data[7]}}, lane_data[7:0]};
            SIZE_HALF: load_data = uns_q ? {16'h0, lane_data[15:0]} :
                                           {{16{lane_data[15]}}, lane_data[15:0]};
            default:   load_data = lane_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (acc_err || we_q) ? 32'h0 : load_data;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
        we_q    <= we_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
